// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation codes, FSM state encoding and small op-decode helpers.
package muldiv_pkg;

   localparam int MDOP_WIDTH = 3;

   localparam logic [MDOP_WIDTH-1:0] MDOP_MULT  = 3'd0;
   localparam logic [MDOP_WIDTH-1:0] MDOP_MULTU = 3'd1;
   localparam logic [MDOP_WIDTH-1:0] MDOP_DIV   = 3'd2;
   localparam logic [MDOP_WIDTH-1:0] MDOP_DIVU  = 3'd3;
   localparam logic [MDOP_WIDTH-1:0] MDOP_MTHI  = 3'd4;
   localparam logic [MDOP_WIDTH-1:0] MDOP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FIX
   } state_t;

   function automatic logic is_arith(input logic [MDOP_WIDTH-1:0] op);
      return (op == MDOP_MULT) || (op == MDOP_MULTU) || (op == MDOP_DIV) || (op == MDOP_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [MDOP_WIDTH-1:0] op);
      return (op == MDOP_MULT) || (op == MDOP_DIV);
   endfunction

   function automatic logic is_mul(input logic [MDOP_WIDTH-1:0] op);
      return (op == MDOP_MULT) || (op == MDOP_MULTU);
   endfunction

endpackage

// File: rtl/muldiv_neg.sv
// Conditional two's-complement negate; used both to take operand magnitudes
// and to restore the sign of results.
module muldiv_neg #(
   parameter int W = 32
) (
   input  logic         neg,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   always_comb begin
      dout = neg ? (~din + W'(1)) : din;
   end

endmodule

// File: rtl/muldiv.sv
// Iterative radix-2 multiply / restoring divide unit owning the HI/LO
// registers; one iteration per cycle, sign fix-up in a final cycle.
module muldiv
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  i_start,
   input  logic [MDOP_WIDTH-1:0] i_op,
   input  logic [WIDTH-1:0]      i_rs,
   input  logic [WIDTH-1:0]      i_rt,
   input  logic                  i_flush,
   output logic                  o_busy,
   output logic                  o_ready,
   output logic [WIDTH-1:0]      o_hi,
   output logic [WIDTH-1:0]      o_lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t             state, state_nxt;
   logic [CW-1:0]      count;
   logic               op_mul, res_sign, rem_sign, div_zero;
   logic [WIDTH-1:0]   opnd;
   logic [2*WIDTH-1:0] acc, step_acc;

   logic               accept, signed_op;
   logic [WIDTH-1:0]   mag_a_in, mag_b_in;
   logic [WIDTH:0]     mul_sum, div_shift;
   logic [WIDTH-1:0]   div_diff;
   logic               div_borrow;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   always_comb begin
      accept    = i_start && !i_flush;
      signed_op = is_signed_op(i_op);
      o_busy    = (state != ST_IDLE);
   end

   muldiv_neg #(.W(WIDTH)) u_neg_a (.neg(signed_op & i_rs[WIDTH-1]), .din(i_rs), .dout(mag_a_in));
   muldiv_neg #(.W(WIDTH)) u_neg_b (.neg(signed_op & i_rt[WIDTH-1]), .din(i_rt), .dout(mag_b_in));

   // A zero divisor yields an all-ones quotient that must not be sign-corrected.
   muldiv_neg #(.W(2*WIDTH)) u_neg_prod (.neg(res_sign), .din(acc), .dout(prod_fix));
   muldiv_neg #(.W(WIDTH)) u_neg_quo (.neg(res_sign & ~div_zero), .din(acc[WIDTH-1:0]), .dout(quo_fix));
   muldiv_neg #(.W(WIDTH)) u_neg_rem (.neg(rem_sign), .din(acc[2*WIDTH-1:WIDTH]), .dout(rem_fix));

   // Multiply: acc = {partial product, multiplier}; divide: acc = {remainder, dividend/quotient}.
   always_comb begin
      mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
      div_shift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_borrow = (div_shift < {1'b0, opnd});
      div_diff   = div_shift[WIDTH-1:0] - opnd;
      if (op_mul) begin
         step_acc = {mul_sum, acc[WIDTH-1:1]};
      end else if (div_borrow) begin
         step_acc = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         step_acc = {div_diff, acc[WIDTH-2:0], 1'b1};
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept && is_arith(i_op)) state_nxt = ST_RUN;
         ST_RUN:  if (i_flush) state_nxt = ST_IDLE;
                  else if (count == CW'(1)) state_nxt = ST_FIX;
         ST_FIX:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
   always_ff @(posedge clk) begin
      if (!nrst) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         o_ready  <= 1'b0;
         o_hi     <= '0;
         o_lo     <= '0;
         count    <= '0;
         op_mul   <= 1'b0;
         res_sign <= 1'b0;
         rem_sign <= 1'b0;
         div_zero <= 1'b0;
         opnd     <= '0;
         acc      <= '0;
      end else begin
         o_ready <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (i_op == MDOP_MTHI) begin
                     o_hi <= i_rs;
                  end else if (i_op == MDOP_MTLO) begin
                     o_lo <= i_rs;
                  end else if (is_arith(i_op)) begin
                     count    <= CW'(WIDTH);
                     op_mul   <= is_mul(i_op);
                     res_sign <= signed_op & (i_rs[WIDTH-1] ^ i_rt[WIDTH-1]);
                     rem_sign <= signed_op & i_rs[WIDTH-1];
                     div_zero <= (i_rt == '0);
                     opnd     <= is_mul(i_op) ? mag_a_in : mag_b_in;
                     acc      <= {{WIDTH{1'b0}}, (is_mul(i_op) ? mag_b_in : mag_a_in)};
                  end
               end
            end
            ST_RUN: begin
               if (!i_flush) begin
                  acc   <= step_acc;
                  count <= count - CW'(1);
               end
            end
            ST_FIX: begin
               if (!i_flush) begin
                  if (op_mul) begin
                     {o_hi, o_lo} <= prod_fix;
                  end else begin
                     o_lo <= quo_fix;
                     o_hi <= rem_fix;
                  end
                  o_ready <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed corner cases plus randomized ops
// compared against a plain-arithmetic model of HI/LO.
module tb_muldiv;

   localparam int W = 32;
   localparam int LAT = W + 1;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          i_start = 1'b0;
   logic [2:0]    i_op = 3'd0;
   logic [W-1:0]  i_rs = '0;
   logic [W-1:0]  i_rt = '0;
   logic          i_flush = 1'b0;
   logic          o_busy, o_ready;
   logic [W-1:0]  o_hi, o_lo;

   int n_checks = 0;
   int n_pass   = 0;
   logic [W-1:0] exp_hi = '0;
   logic [W-1:0] exp_lo = '0;

   muldiv #(.WIDTH(W)) dut (
      .clk(clk), .nrst(nrst), .i_start(i_start), .i_op(i_op), .i_rs(i_rs), .i_rt(i_rt),
      .i_flush(i_flush), .o_busy(o_busy), .o_ready(o_ready), .o_hi(o_hi), .o_lo(o_lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   // Reference: what HI/LO must hold after the op, from plain integer arithmetic.
   task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, sq, sr;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd0: begin p = sa * sb; {exp_hi, exp_lo} = p; end
         3'd1: begin p = {32'b0, a} * {32'b0, b}; {exp_hi, exp_lo} = p; end
         3'd2: if (b == 0) begin exp_lo = '1; exp_hi = a; end
               else begin sq = sa / sb; sr = sa % sb; exp_lo = sq[31:0]; exp_hi = sr[31:0]; end
         3'd3: if (b == 0) begin exp_lo = '1; exp_hi = a; end
               else begin exp_lo = a / b; exp_hi = a % b; end
         3'd4: exp_hi = a;
         3'd5: exp_lo = a;
         default: ;
      endcase
   endtask

   task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      i_start = 1'b1; i_op = op; i_rs = a; i_rt = b;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   // flush_at: busy-cycle number at which to pulse i_flush (0 = never);
   // poke_at: busy-cycle number at which to raise a stray i_start (0 = never).
   task automatic run_arith(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int flush_at, input int poke_at);
      int n;
      logic early_ready, leaked;
      logic [W-1:0] old_hi, old_lo;
      old_hi = exp_hi; old_lo = exp_lo;
      if (flush_at == 0) model(op, a, b);
      start_op(op, a, b);
      n = 0; early_ready = 1'b0; leaked = 1'b0;
      while (o_busy && n < 100) begin
         n++;
         if (o_ready) early_ready = 1'b1;
         if (o_hi !== old_hi || o_lo !== old_lo) leaked = 1'b1;
         if (n == flush_at) i_flush = 1'b1;
         if (n == poke_at) begin i_start = 1'b1; i_op = 3'd1; i_rs = 32'h1234; i_rt = 32'h5678; end
         if (n == poke_at + 1) i_start = 1'b0;
         @(negedge clk);
      end
      i_flush = 1'b0; i_start = 1'b0;
      check({tag, "_busy_cycles"}, 64'(n), 64'((flush_at != 0) ? flush_at : LAT));
      check({tag, "_ready"}, 64'(o_ready), 64'(flush_at == 0));
      check({tag, "_hi"}, 64'(o_hi), 64'(exp_hi));
      check({tag, "_lo"}, 64'(o_lo), 64'(exp_lo));
      check({tag, "_no_early_ready"}, 64'(early_ready), 64'(0));
      check({tag, "_hilo_hidden"}, 64'(leaked), 64'(0));
      @(negedge clk);
      check({tag, "_ready_one_shot"}, 64'(o_ready), 64'(0));
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return 32'h1;
         2: return '1;
         3: return 32'h8000_0000;
         4: return W'($urandom_range(0, 20));
         default: return W'($urandom());
      endcase
   endfunction

   initial begin
      repeat (2) @(negedge clk);
      check("rst_hi", 64'(o_hi), 64'(0));
      check("rst_lo", 64'(o_lo), 64'(0));
      check("rst_busy", 64'(o_busy), 64'(0));
      check("rst_ready", 64'(o_ready), 64'(0));
      nrst = 1'b1;

      run_arith("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      check("multu_max_hi_const", 64'(o_hi), 64'h0000_0000_FFFF_FFFE);
      check("multu_max_lo_const", 64'(o_lo), 64'h0000_0000_0000_0001);
      run_arith("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 0, 0);
      run_arith("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
      run_arith("divu_zero", 3'd3, 32'd100, 32'd0, 0, 0);
      run_arith("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      run_arith("div_neg_zero", 3'd2, 32'h8000_0000, 32'd0, 0, 0);

      // Back-to-back MTHI / MTLO
      @(negedge clk);
      i_start = 1'b1; i_op = 3'd4; i_rs = 32'h1234_5678;
      @(negedge clk);
      exp_hi = 32'h1234_5678;
      check("mthi_hi", 64'(o_hi), 64'(exp_hi));
      check("mthi_busy", 64'(o_busy), 64'(0));
      i_op = 3'd5; i_rs = 32'hCAFE_BABE;
      @(negedge clk);
      i_start = 1'b0;
      exp_lo = 32'hCAFE_BABE;
      check("mtlo_lo", 64'(o_lo), 64'(exp_lo));
      check("mtlo_hi_kept", 64'(o_hi), 64'(exp_hi));
      check("mtlo_busy", 64'(o_busy), 64'(0));
      check("mtlo_ready", 64'(o_ready), 64'(0));

      run_arith("divu_poke", 3'd3, 32'd1000, 32'd7, 0, 5);

      // Flush mid-run with preset HI/LO, then immediate restart
      start_op(3'd4, 32'hAAAA, 32'h0); exp_hi = 32'hAAAA;
      start_op(3'd5, 32'h5555, 32'h0); exp_lo = 32'h5555;
      run_arith("flush_run", 3'd3, 32'd12345, 32'd11, 10, 0);
      run_arith("after_flush", 3'd1, 32'd123456, 32'd654321, 0, 0);
      run_arith("flush_fix", 3'd0, 32'hFFFF_0000, 32'd3, LAT, 0);

      // Flush in IDLE discards a simultaneous start
      @(negedge clk);
      i_start = 1'b1; i_flush = 1'b1; i_op = 3'd4; i_rs = 32'hDEAD_BEEF;
      @(negedge clk);
      check("idle_flush_hi", 64'(o_hi), 64'(exp_hi));
      i_op = 3'd3; i_rs = 32'd9; i_rt = 32'd2;
      @(negedge clk);
      i_start = 1'b0; i_flush = 1'b0;
      check("idle_flush_busy", 64'(o_busy), 64'(0));

      // Reset mid-operation
      start_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (19) @(negedge clk);
      nrst = 1'b0;
      @(negedge clk);
      exp_hi = '0; exp_lo = '0;
      check("midrst_hi", 64'(o_hi), 64'(0));
      check("midrst_lo", 64'(o_lo), 64'(0));
      check("midrst_busy", 64'(o_busy), 64'(0));
      nrst = 1'b1;
      run_arith("post_rst", 3'd1, 32'd6, 32'd7, 0, 0);

      for (int i = 0; i < 40; i++) begin
         logic [2:0] op;
         logic [W-1:0] a, b;
         int fl;
         op = 3'($urandom_range(0, 7));
         a = pick(); b = pick();
         if (op <= 3'd3) begin
            fl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, LAT)) : 0;
            run_arith("rnd_arith", op, a, b, fl, 0);
         end else begin
            model(op, a, b);
            start_op(op, a, b);
            check("rnd_move_hi", 64'(o_hi), 64'(exp_hi));
            check("rnd_move_lo", 64'(o_lo), 64'(exp_lo));
            check("rnd_move_busy", 64'(o_busy), 64'(0));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
